seg7_scan_driver: RTL and testbench

//  Time-multiplexed N-digit hex 7-segment driver for the board display path.

---
 rtl/seg7_scan_driver_pkg.sv | 23 ++
 rtl/seg7_scan_driver_if.sv | 27 ++
 rtl/seg7_scan_driver_hex_lut.sv | 34 +++
 rtl/seg7_scan_driver.sv | 119 +++++++++++
 tb/tb_seg7_scan_driver.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment hex display driver.
//   SEG_OFF_AL    : all segments dark, active-low gfedcba
//   SEG_TABLE_AL  : hex digit -> active-low gfedcba pattern
//   onehot()      : one-hot vector of ONEHOT_MAX bits with bit idx set
package seg7_scan_driver_pkg;

    localparam int unsigned ONEHOT_MAX = 32;

    localparam logic [6:0] SEG_OFF_AL = 7'b1111111;

    localparam logic [6:0] SEG_TABLE_AL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Callers truncate to their own digit count; supports up to ONEHOT_MAX digits.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
        return ONEHOT_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the value source and the scan driver.
//   Value     : packed nibbles, Value[3:0] = digit 0
//   Load      : capture Value into the shadow register
//   Blank_lz  : enable leading-zero blanking
//   Seg       : segment pins {g,f,e,d,c,b,a}
//   Dig_en    : one-hot digit enables
//   Scan_wrap : one-cycle pulse when the scan returns to digit 0
interface seg7_scan_driver_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] Value;
    logic                  Load;
    logic                  Blank_lz;
    logic [6:0]            Seg;
    logic [N_DIGITS-1:0]   Dig_en;
    logic                  Scan_wrap;

    modport master (
        output Value, Load, Blank_lz,
        input  Seg, Dig_en, Scan_wrap
    );

    modport slave (
        input  Value, Load, Blank_lz,
        output Seg, Dig_en, Scan_wrap
    );
endinterface

// File: rtl/seg7_scan_driver_hex_lut.sv
// Hex nibble to active-low 7-segment pattern.
//   i_nib    : hex digit
//   o_seg_al : active-low gfedcba
module seg7_hex_lut
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg_al
);

    always_comb begin
        o_seg_al = SEG_OFF_AL;
        case (i_nib)
            4'h0: o_seg_al = SEG_TABLE_AL[0];
            4'h1: o_seg_al = SEG_TABLE_AL[1];
            4'h2: o_seg_al = SEG_TABLE_AL[2];
            4'h3: o_seg_al = SEG_TABLE_AL[3];
            4'h4: o_seg_al = SEG_TABLE_AL[4];
            4'h5: o_seg_al = SEG_TABLE_AL[5];
            4'h6: o_seg_al = SEG_TABLE_AL[6];
            4'h7: o_seg_al = SEG_TABLE_AL[7];
            4'h8: o_seg_al = SEG_TABLE_AL[8];
            4'h9: o_seg_al = SEG_TABLE_AL[9];
            4'hA: o_seg_al = SEG_TABLE_AL[10];
            4'hB: o_seg_al = SEG_TABLE_AL[11];
            4'hC: o_seg_al = SEG_TABLE_AL[12];
            4'hD: o_seg_al = SEG_TABLE_AL[13];
            4'hE: o_seg_al = SEG_TABLE_AL[14];
            4'hF: o_seg_al = SEG_TABLE_AL[15];
            default: o_seg_al = SEG_OFF_AL;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with one dark cycle per slot.
//   Clock  : rising-edge clock
//   Resetn : synchronous active-low reset
//   bus    : slave side of seg7_scan_driver_if (Value/Load/Blank_lz in,
//            registered Seg/Dig_en/Scan_wrap out)
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned SEG_ACT_LOW = 1,
    parameter int unsigned DIG_ACT_LOW = 0
) (
    input  logic              Clock,
    input  logic              Resetn,
    seg7_scan_driver_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * N_DIGITS;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_OFF  = (SEG_ACT_LOW != 0) ? SEG_OFF_AL : ~SEG_OFF_AL;
    localparam logic [N_DIGITS-1:0] DIG_OFF  = (DIG_ACT_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [VAL_W-1:0]    r_shadow;
    logic [6:0]          r_seg;
    logic [N_DIGITS-1:0] r_dig;
    logic                r_wrap;

    logic                w_slot_end;
    logic [N_DIGITS-1:0] w_blank;
    logic [3:0]          w_nib;
    logic                w_cur_blank;
    logic [6:0]          w_seg_al;
    logic [6:0]          w_seg_next;
    logic [N_DIGITS-1:0] w_dig_next;

    assign w_slot_end = (r_cnt == CNT_LAST);

    // Leading-zero mask: digit i blanks when it and every digit above it are zero.
    always_comb begin
        logic w_zero_above;
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_shadow[4*i +: 4] == 4'h0);
            if (i != 0) begin
                w_blank[i] = bus.Blank_lz && w_zero_above;
            end
        end
    end

    // Select the nibble and blank flag of the digit currently being scanned.
    always_comb begin
        w_nib       = 4'h0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_shadow[4*i +: 4];
                w_cur_blank = w_blank[i];
            end
        end
    end

    seg7_hex_lut u_lut (
        .i_nib    (w_nib),
        .o_seg_al (w_seg_al)
    );

    // Apply blanking and pin polarity to the lit-cycle outputs.
    always_comb begin
        w_seg_next = w_cur_blank ? SEG_OFF_AL : w_seg_al;
        if (SEG_ACT_LOW == 0) begin
            w_seg_next = ~w_seg_next;
        end
        w_dig_next = N_DIGITS'(onehot(32'(r_idx)));
        if (DIG_ACT_LOW != 0) begin
            w_dig_next = ~w_dig_next;
        end
    end

    // Prescaler, digit index, shadow capture and registered pin drivers.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_seg    <= SEG_OFF;
            r_dig    <= DIG_OFF;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= w_slot_end && (r_idx == IDX_LAST);
            if (bus.Load) begin
                r_shadow <= bus.Value;
            end
            if (w_slot_end) begin
                // Dead cycle between digits to keep the old pattern off the new anode.
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
                r_seg <= SEG_OFF;
                r_dig <= DIG_OFF;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_seg <= w_seg_next;
                r_dig <= w_dig_next;
            end
        end
    end

    assign bus.Seg       = r_seg;
    assign bus.Dig_en    = r_dig;
    assign bus.Scan_wrap = r_wrap;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int unsigned N = 4;
    localparam int unsigned P = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.N_DIGITS(N)) bus ();
    seg7_scan_driver_if #(.N_DIGITS(N)) pbus ();

    seg7_scan_driver #(
        .N_DIGITS(N), .PRESCALE(P), .SEG_ACT_LOW(1), .DIG_ACT_LOW(0)
    ) dut (
        .Clock(clk), .Resetn(rstn), .bus(bus)
    );

    seg7_scan_driver #(
        .N_DIGITS(N), .PRESCALE(P), .SEG_ACT_LOW(0), .DIG_ACT_LOW(1)
    ) dut_pol (
        .Clock(clk), .Resetn(rstn), .bus(pbus)
    );

    int errors = 0;
    int checks = 0;

    // Active-low gfedcba codes for hex 0..F.
    logic [6:0] enc_al [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: m_k = edges since the last reset edge, m_shadow = latched value.
    int unsigned m_k      = 0;
    logic [15:0] m_shadow = '0;
    logic [6:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_wrap;

    typedef struct {
        logic        rstn;
        logic        load;
        logic [15:0] value;
        logic        blank;
        logic [6:0]  seg;
        logic [3:0]  dig;
        logic        wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0b want=%0b", name, act, exp);
        end
    endtask

    function automatic bit digit_blank(input int d);
        return bus.Blank_lz && (d != 0) && ((m_shadow >> (4 * d)) == 16'h0);
    endfunction

    // Expected outputs after the coming edge, from the scan position and current inputs.
    task automatic model_edge();
        int phase;
        int digit;
        if (!rstn) begin
            m_k      = 0;
            m_shadow = '0;
            e_seg    = 7'b1111111;
            e_dig    = 4'b0000;
            e_wrap   = 1'b0;
        end else begin
            phase = int'(m_k % P);
            digit = int'((m_k / P) % N);
            if (phase == int'(P) - 1) begin
                e_seg = 7'b1111111;
                e_dig = 4'b0000;
            end else begin
                e_dig = 4'(1 << digit);
                e_seg = digit_blank(digit) ? 7'b1111111
                                           : enc_al[4'((m_shadow >> (4 * digit)) & 16'hF)];
            end
            e_wrap = ((m_k % (N * P)) == (N * P - 1));
            if (bus.Load) m_shadow = bus.Value;
            m_k++;
        end
    endtask

    task automatic step(input string name);
        model_edge();
        @(posedge clk);
        #1;
        check({name, ".seg"},  32'(bus.Seg),       32'(e_seg));
        check({name, ".dig"},  32'(bus.Dig_en),    32'(e_dig));
        check({name, ".wrap"}, 32'(bus.Scan_wrap), 32'(e_wrap));
    endtask

    task automatic drive(input logic r, input logic ld, input logic [15:0] v, input logic bl);
        rstn         = r;
        bus.Load     = ld;
        bus.Value    = v;
        bus.Blank_lz = bl;
    endtask

    function automatic vec_t mk(input logic r, input logic ld, input logic [15:0] v,
                                input logic bl, input logic [6:0] s, input logic [3:0] d,
                                input logic w);
        vec_t t;
        t.rstn = r; t.load = ld; t.value = v; t.blank = bl;
        t.seg = s; t.dig = d; t.wrap = w;
        return t;
    endfunction

    initial begin
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        pbus.Load     = 1'b0;
        pbus.Value    = 16'h0;
        pbus.Blank_lz = 1'b0;

        // Reset, release with a load of 0x12AF, then one full scan revolution.
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 16'h0, 0, 7'b1111111, 4'b0000, 0));
        vecs.push_back(mk(1, 1, 16'h12AF, 0, 7'b1000000, 4'b0001, 0));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(1, 0, 16'h0, 0, 7'b0001110, 4'b0001, 0));
        vecs.push_back(mk(1, 0, 16'h0, 0, 7'b1111111, 4'b0000, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 16'h0, 0, 7'b0001000, 4'b0010, 0));
        vecs.push_back(mk(1, 0, 16'h0, 0, 7'b1111111, 4'b0000, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 16'h0, 0, 7'b0100100, 4'b0100, 0));
        vecs.push_back(mk(1, 0, 16'h0, 0, 7'b1111111, 4'b0000, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 16'h0, 0, 7'b1111001, 4'b1000, 0));
        vecs.push_back(mk(1, 0, 16'h0, 0, 7'b1111111, 4'b0000, 1));
        vecs.push_back(mk(1, 0, 16'h0, 0, 7'b0001110, 4'b0001, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rstn, vecs[i].load, vecs[i].value, vecs[i].blank);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tseg", i),  32'(bus.Seg),       32'(vecs[i].seg));
            check($sformatf("vec%0d.tdig", i),  32'(bus.Dig_en),    32'(vecs[i].dig));
            check($sformatf("vec%0d.twrap", i), 32'(bus.Scan_wrap), 32'(vecs[i].wrap));
        end

        // Leading-zero blanking of 0x0005, then of 0x0000.
        drive(0, 0, 16'h0, 1); step("blk_rst");
        drive(1, 1, 16'h0005, 1); step("blk_k0");
        drive(1, 0, 16'h0, 1); step("blk_k1");
        check("blk_d0", 32'(bus.Seg), 32'(7'b0010010));
        step("blk_k2"); step("blk_k3"); step("blk_k4");
        check("blk_d1", 32'(bus.Seg), 32'(7'b1111111));
        check("blk_d1en", 32'(bus.Dig_en), 32'(4'b0010));
        drive(1, 1, 16'h0000, 1); step("blk_ld0");
        drive(1, 0, 16'h0, 1);
        for (int i = 0; i < 16; i++) step("blk_zero");

        // Load mid-slot: new nibble shows on the next cycle, slot length unchanged.
        drive(0, 0, 16'h0, 0); step("mid_rst");
        drive(1, 1, 16'h000F, 0); step("mid_k0");
        drive(1, 1, 16'h0003, 0); step("mid_k1");
        check("mid_old", 32'(bus.Seg), 32'(7'b0001110));
        drive(1, 0, 16'h0, 0); step("mid_k2");
        check("mid_new", 32'(bus.Seg), 32'(7'b0110000));
        check("mid_dig", 32'(bus.Dig_en), 32'(4'b0001));
        step("mid_k3");
        check("mid_dead", 32'(bus.Dig_en), 32'(4'b0000));

        // Reset while digit 2 is being scanned.
        drive(0, 0, 16'h0, 0); step("rms_rst");
        drive(1, 1, 16'h4321, 0); step("rms_k0");
        drive(1, 0, 16'h0, 0);
        for (int i = 1; i <= 8; i++) step("rms_run");
        check("rms_idx2", 32'(bus.Dig_en), 32'(4'b0100));
        drive(0, 0, 16'h0, 0); step("rms_hit");
        check("rms_off_seg", 32'(bus.Seg), 32'(7'b1111111));
        check("rms_off_dig", 32'(bus.Dig_en), 32'(4'b0000));
        drive(1, 0, 16'h0, 0); step("rms_rel");
        check("rms_rel_seg", 32'(bus.Seg), 32'(7'b1000000));
        check("rms_rel_dig", 32'(bus.Dig_en), 32'(4'b0001));

        // Inverted polarity instance: segments active-high, digits active-low.
        drive(0, 0, 16'h0, 0); step("pol_rst");
        check("pol_rst_seg", 32'(pbus.Seg), 32'(7'b0000000));
        check("pol_rst_dig", 32'(pbus.Dig_en), 32'(4'b1111));
        pbus.Load = 1'b1; pbus.Value = 16'h0008;
        drive(1, 0, 16'h0, 0); step("pol_k0");
        check("pol_k0_seg", 32'(pbus.Seg), 32'(7'b0111111));
        pbus.Load = 1'b0;
        step("pol_k1");
        check("pol_k1_seg", 32'(pbus.Seg), 32'(7'b1111111));
        check("pol_k1_dig", 32'(pbus.Dig_en), 32'(4'b1110));
        step("pol_k2");
        step("pol_k3");
        check("pol_dead_seg", 32'(pbus.Seg), 32'(7'b0000000));
        check("pol_dead_dig", 32'(pbus.Dig_en), 32'(4'b1111));

        // Randomized traffic against the model, including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            logic bl;
            bl = ($urandom_range(0, 7) == 0) ? ~bus.Blank_lz : bus.Blank_lz;
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
                  (($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom)),
                  bl);
            step($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
